rx232_byte: RTL and testbench

UART receive deserializer feeding the RX232 packet-capture stage. Samples the asynchronous serial line, recovers 8-bit characters (8N1, optional even parity), and presents each good byte on `rxpd` with a multi-cycle `rnpd` strobe. It also drives a frame-enable `rxen` that brackets a burst of back-to-back characters, so the downstream 4-byte packet assembler can align its byte counter.

---
 rtl/rx232_byte.sv | 182 ++++++++++++++++++
 tb/tb_rx232_byte.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx232_byte.sv
// rtl/rx232_byte.sv - UART 8N1/8E1 receive deserializer with rnpd strobe and rxen frame bracket
// Optional even parity is enabled by defining RX232_PARITY_EN.
module rx232_byte #(
    parameter int CLK_DIV   = 434,
    parameter int PULSE_W   = 4,
    parameter int IDLE_BITS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       rxen,
    output logic       rnpd,
    output logic [7:0] rxpd,
    output logic       frm_err,
    output logic       par_err
);
    localparam int CW     = $clog2(CLK_DIV + 1);
    localparam int PW     = $clog2(PULSE_W + 1);
    localparam int IDLE_T = IDLE_BITS * CLK_DIV;
    localparam int IW     = $clog2(IDLE_T + 1);

    localparam logic [CW-1:0] HALF  = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] FULL  = CW'(CLK_DIV);
    localparam logic [CW-1:0] C1    = CW'(1);
    localparam logic [PW-1:0] P1    = PW'(1);
    localparam logic [PW-1:0] PLAST = PW'(PULSE_W - 1);
    localparam logic [IW-1:0] I1    = IW'(1);
    localparam logic [IW-1:0] ILAST = IW'(IDLE_T - 1);
    localparam logic [IW-1:0] IMAX  = IW'(IDLE_T);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef RX232_PARITY_EN
        S_PAR,
`endif
        S_STOP,
        S_WAITHI
    } state_t;

    state_t          state;
    logic            sync1;
    logic            rxs;
    logic [1:0]      sync_ok;
    logic            armed;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      sh;
    logic [PW-1:0]   pcnt;
    logic [IW-1:0]   icnt;
`ifdef RX232_PARITY_EN
    logic            par_ok;
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            sync1   <= 1'b1;
            rxs     <= 1'b1;
            sync_ok <= 2'b00;
            armed   <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            pcnt    <= '0;
            icnt    <= '0;
            rxen    <= 1'b0;
            rnpd    <= 1'b0;
            rxpd    <= 8'hFF;
            frm_err <= 1'b0;
`ifdef RX232_PARITY_EN
            par_ok  <= 1'b1;
            par_err <= 1'b0;
`endif
        end else begin
            sync1   <= rxd;
            rxs     <= sync1;
            // Arm only once a real high level has passed the synchronizer, so a
            // line held low through reset is never mistaken for a start edge.
            sync_ok <= {sync_ok[0], 1'b1};
            if (sync_ok[1] && rxs) armed <= 1'b1;

            frm_err <= 1'b0;
`ifdef RX232_PARITY_EN
            par_err <= 1'b0;
`endif
            if (rnpd) begin
                if (pcnt == '0) rnpd <= 1'b0;
                else            pcnt <= pcnt - P1;
            end

            if (state == S_IDLE && rxen) begin
                if (icnt == ILAST) begin
                    rxen <= 1'b0;
                    icnt <= IMAX;
                end else if (icnt != IMAX) begin
                    icnt <= icnt + I1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (armed && !rxs) begin
                        cnt   <= HALF;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == C1) begin
                        if (rxs) begin
                            state <= S_IDLE;
                        end else begin
                            rxen    <= 1'b1;
                            icnt    <= '0;
                            cnt     <= FULL;
                            bit_idx <= '0;
                            state   <= S_DATA;
                        end
                    end else begin
                        cnt <= cnt - C1;
                    end
                end
                S_DATA: begin
                    if (cnt == C1) begin
                        sh  <= {rxs, sh[7:1]};
                        cnt <= FULL;
                        if (bit_idx == 3'd7) begin
`ifdef RX232_PARITY_EN
                            state <= S_PAR;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - C1;
                    end
                end
`ifdef RX232_PARITY_EN
                S_PAR: begin
                    if (cnt == C1) begin
                        par_ok <= ~(^{rxs, sh});
                        cnt    <= FULL;
                        state  <= S_STOP;
                    end else begin
                        cnt <= cnt - C1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt == C1) begin
                        if (!rxs) begin
                            frm_err <= 1'b1;
                            rxen    <= 1'b0;
                            state   <= S_WAITHI;
`ifdef RX232_PARITY_EN
                        end else if (!par_ok) begin
                            par_err <= 1'b1;
                            state   <= S_IDLE;
`endif
                        end else begin
                            rxpd  <= sh;
                            rnpd  <= 1'b1;
                            pcnt  <= PLAST;
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - C1;
                    end
                end
                S_WAITHI: begin
                    if (rxs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rx232_byte.sv
// tb/tb_rx232_byte.sv - self-checking bench for rx232_byte (table, corner sequences, random bytes)
module tb_rx232_byte;
    localparam int D  = 16;
    localparam int PW = 4;
    localparam int IB = 20;
`ifdef RX232_PARITY_EN
    localparam int NSLOT = 10;
`else
    localparam int NSLOT = 9;
`endif
    // pin edge in cycle k -> first cycle rnpd is seen high
    localparam int OFF  = 3 + D / 2 + NSLOT * D;
    localparam int IDLE = IB * D;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rxen, rnpd, frm_err, par_err;
    logic [7:0] rxpd;

    rx232_byte #(.CLK_DIV(D), .PULSE_W(PW), .IDLE_BITS(IB)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rxen(rxen), .rnpd(rnpd),
        .rxpd(rxpd), .frm_err(frm_err), .par_err(par_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         rise_cyc[$];
    logic [7:0] rise_val[$];
    int         widths[$];
    int         rxen_rise[$];
    int         rxen_fall[$];
    int         frm_cyc[$];
    int         par_cyc[$];
    int         stab_err = 0;
    int         fall_rnpd = 0;
    int         par_total = 0;
    logic       prnpd = 1'b0;
    logic       prxen = 1'b0;
    logic [7:0] held = 8'h00;
    int         hw = 0;

    always @(negedge clk) begin
        if (rnpd === 1'b1) begin
            if (prnpd !== 1'b1) begin
                rise_cyc.push_back(cyc);
                rise_val.push_back(rxpd);
                held = rxpd;
                hw = 1;
            end else begin
                hw++;
                if (rxpd !== held) stab_err++;
            end
        end else if (prnpd === 1'b1) begin
            widths.push_back(hw);
        end
        if (rxen === 1'b1 && prxen !== 1'b1) rxen_rise.push_back(cyc);
        if (rxen !== 1'b1 && prxen === 1'b1) begin
            rxen_fall.push_back(cyc);
            if (rnpd === 1'b1) fall_rnpd++;
        end
        if (frm_err === 1'b1) frm_cyc.push_back(cyc);
        if (par_err === 1'b1) begin
            par_cyc.push_back(cyc);
            par_total++;
        end
        prnpd = rnpd;
        prxen = rxen;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    endtask

    task automatic clear_mon();
        rise_cyc.delete(); rise_val.delete(); widths.delete();
        rxen_rise.delete(); rxen_fall.delete(); frm_cyc.delete(); par_cyc.delete();
    endtask

    function automatic int qi(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    function automatic int qv(input logic [7:0] q[$], input int i);
        return (q.size() > i) ? int'(q[i]) : -1;
    endfunction

    // Serial frame at the pin; k is the cycle in which the start bit begins.
    task automatic send_frame(input logic [7:0] d, input bit stop_v, input int stop_len,
                              input bit par_flip, output int k);
        @(posedge clk); #1;
        rxd = 1'b0;
        k = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (D) @(posedge clk); #1;
            rxd = d[i];
        end
`ifdef RX232_PARITY_EN
        repeat (D) @(posedge clk); #1;
        rxd = (^d) ^ par_flip;
`endif
        repeat (D) @(posedge clk); #1;
        rxd = stop_v;
        repeat (stop_len - 1) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rxen"}, int'(rxen), 0);
        chk({tag, "_rnpd"}, int'(rnpd), 0);
        chk({tag, "_rxpd"}, int'(rxpd), 8'hFF);
        chk({tag, "_frm_err"}, int'(frm_err), 0);
        chk({tag, "_par_err"}, int'(par_err), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         exp_rnpd;
        bit         exp_frm;
        bit         exp_rxen;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[6];
        int         k, k1, k2, k4;
        logic [7:0] last_good;
        int         exp_c[$];
        logic [7:0] exp_v[$];

        vecs[0] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h96, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1};

        // reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        #1 rst = 1'b0;
        idle(10);

        // single byte A5 with full idle timeout
        clear_mon();
        send_frame(8'hA5, 1'b1, 16, 1'b0, k);
        idle(IDLE + 40);
        chk("a5_rxen_rise", qi(rxen_rise, 0), k + 3 + D / 2);
        chk("a5_rnpd_count", rise_cyc.size(), 1);
        chk("a5_rnpd_cycle", qi(rise_cyc, 0), k + OFF);
        chk("a5_rxpd", qv(rise_val, 0), 8'hA5);
        chk("a5_rnpd_width", qi(widths, 0), PW);
        chk("a5_rxen_fall", qi(rxen_fall, 0), k + OFF + IDLE);
        chk("a5_rxpd_held", int'(rxpd), 8'hA5);

        // four back-to-back bytes
        clear_mon();
        send_frame(8'h01, 1'b1, 16, 1'b0, k1);
        exp_c.push_back(k1 + OFF);
        send_frame(8'h02, 1'b1, 16, 1'b0, k);
        exp_c.push_back(k + OFF);
        send_frame(8'h03, 1'b1, 16, 1'b0, k);
        exp_c.push_back(k + OFF);
        send_frame(8'h04, 1'b1, 16, 1'b0, k4);
        exp_c.push_back(k4 + OFF);
        idle(20);
        chk("b2b_count", rise_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_val%0d", i), qv(rise_val, i), i + 1);
            chk($sformatf("b2b_cyc%0d", i), qi(rise_cyc, i), exp_c[i]);
        end
        chk("b2b_rxen_rises", rxen_rise.size(), 1);
        chk("b2b_no_rxen_fall", rxen_fall.size(), 0);
        chk("b2b_rxen_high", int'(rxen), 1);
        idle(IDLE);
        chk("b2b_rxen_fall", qi(rxen_fall, 0), k4 + OFF + IDLE);
        exp_c.delete();
        last_good = 8'h04;

        // 5-clock glitch on idle line
        clear_mon();
        rxd = 1'b0;
        idle(5);
        rxd = 1'b1;
        idle(40);
        chk("glitch_no_rxen", rxen_rise.size(), 0);
        chk("glitch_no_rnpd", rise_cyc.size(), 0);
        chk("glitch_rxen_low", int'(rxen), 0);

        // table: good bytes and framing errors
        for (int v = 0; v < 6; v++) begin
            clear_mon();
            send_frame(vecs[v].data, vecs[v].stop_ok, 16, 1'b0, k);
            if (!vecs[v].stop_ok) begin
                idle(40);
                rxd = 1'b1;
            end
            idle(40);
            if (vecs[v].exp_rnpd) last_good = vecs[v].data;
            chk($sformatf("vec%0d_rnpd_count", v), rise_cyc.size(), int'(vecs[v].exp_rnpd));
            if (vecs[v].exp_rnpd) begin
                chk($sformatf("vec%0d_rnpd_cycle", v), qi(rise_cyc, 0), k + OFF);
                chk($sformatf("vec%0d_rnpd_val", v), qv(rise_val, 0), int'(vecs[v].data));
            end
            chk($sformatf("vec%0d_frm_count", v), frm_cyc.size(), int'(vecs[v].exp_frm));
            if (vecs[v].exp_frm)
                chk($sformatf("vec%0d_frm_cycle", v), qi(frm_cyc, 0), k + OFF);
            chk($sformatf("vec%0d_rxpd", v), int'(rxpd), int'(last_good));
            chk($sformatf("vec%0d_rxen", v), int'(rxen), int'(vecs[v].exp_rxen));
        end

        // next start in the very first clock after the stop sample
        clear_mon();
        send_frame(8'hC3, 1'b1, 9, 1'b0, k1);
        send_frame(8'h6E, 1'b1, 16, 1'b0, k2);
        idle(30);
        chk("tight_count", rise_cyc.size(), 2);
        chk("tight_cyc0", qi(rise_cyc, 0), k1 + OFF);
        chk("tight_cyc1", qi(rise_cyc, 1), k2 + OFF);
        chk("tight_val0", qv(rise_val, 0), 8'hC3);
        chk("tight_val1", qv(rise_val, 1), 8'h6E);
        last_good = 8'h6E;

        // reset mid-DATA with the line held low through and after reset
        clear_mon();
        rxd = 1'b0;
        idle(60);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("midrst");
        rst = 1'b0;
        clear_mon();
        idle(100);
        chk("midrst_low_no_rxen", rxen_rise.size(), 0);
        chk("midrst_low_no_rnpd", rise_cyc.size(), 0);
        rxd = 1'b1;
        idle(20);
        send_frame(8'h5A, 1'b1, 16, 1'b0, k);
        idle(30);
        chk("midrst_5a_count", rise_cyc.size(), 1);
        chk("midrst_5a_cycle", qi(rise_cyc, 0), k + OFF);
        chk("midrst_5a_val", qv(rise_val, 0), 8'h5A);
        last_good = 8'h5A;

        // random bytes, random short stop bits and idle gaps
        clear_mon();
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1, int'($urandom_range(9, 16)), 1'b0, k);
            exp_c.push_back(k + OFF);
            exp_v.push_back(d);
            repeat ($urandom_range(0, 20)) @(posedge clk);
        end
        idle(30);
        chk("rand_count", rise_cyc.size(), 12);
        chk("rand_widths", widths.size(), 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("rand_val%0d", i), qv(rise_val, i), int'(exp_v[i]));
            chk($sformatf("rand_cyc%0d", i), qi(rise_cyc, i), exp_c[i]);
            chk($sformatf("rand_width%0d", i), qi(widths, i), PW);
        end
        last_good = exp_v[11];

        // parity: 07 with wrong then right parity bit
        clear_mon();
        send_frame(8'h07, 1'b1, 16, 1'b1, k);
        idle(30);
`ifdef RX232_PARITY_EN
        chk("par_bad_no_rnpd", rise_cyc.size(), 0);
        chk("par_bad_par_err", par_cyc.size(), 1);
        chk("par_bad_cycle", qi(par_cyc, 0), k + OFF);
        chk("par_bad_rxpd", int'(rxpd), int'(last_good));
        chk("par_bad_rxen", int'(rxen), 1);
`else
        chk("nopar_rnpd", rise_cyc.size(), 1);
        chk("nopar_val", qv(rise_val, 0), 8'h07);
`endif
        chk("par_bad_no_frm", frm_cyc.size(), 0);
        clear_mon();
        send_frame(8'h07, 1'b1, 16, 1'b0, k);
        idle(30);
        chk("par_good_rnpd", rise_cyc.size(), 1);
        chk("par_good_cycle", qi(rise_cyc, 0), k + OFF);
        chk("par_good_val", qv(rise_val, 0), 8'h07);
        chk("par_good_no_par_err", par_cyc.size(), 0);

        // whole-run guarantees
        chk("rxpd_stable_during_rnpd", stab_err, 0);
        chk("rxen_fall_during_rnpd", fall_rnpd, 0);
`ifndef RX232_PARITY_EN
        chk("par_err_never", par_total, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
